result_pipe: RTL and testbench

RESULT_PIPE -- requirements
Module: result_pipe

---
 rtl/defines_pkg.sv | 22 ++
 rtl/rp_stage.sv | 24 ++
 rtl/result_pipe.sv | 148 ++++++++++++++
 tb/tb_result_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
// Shared types and constants for the result pipeline.
package defines_pkg;

  localparam int unsigned NUM_STAGES     = 7;
  localparam int unsigned WB_STAGE       = NUM_STAGES + 1;
  localparam int unsigned FLUSH_KEEP_DEF = 4;
  localparam int unsigned IDX_WD         = 3;
  localparam int unsigned ENTRY_DATA_WD  = 128;
  localparam int unsigned ENTRY_ADDR_WD  = 7;

  // Unit index 0 means "no result available".
  localparam logic [IDX_WD-1:0] IDX_NONE = '0;

  typedef struct packed {
    logic                     vld;
    logic [ENTRY_ADDR_WD-1:0] rt;
    logic [IDX_WD-1:0]        idx;
    logic                     rdy;
    logic [ENTRY_DATA_WD-1:0] data;
  } entry_t;

endpackage

// File: rtl/rp_stage.sv
// One pipeline entry register with capture and kill controls.
module rp_stage
  import defines_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   capture,
  input  logic   kill,
  input  entry_t d,
  output entry_t q
);

  // Kill empties the slot; otherwise load the incoming entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (capture) begin
      q <= d;
    end
  end

endmodule

// File: rtl/result_pipe.sv
// Result pipeline: issued entries march s2..s7 then writeback, collecting
// completions on the way and exposing a bypass view of every stage.
module result_pipe
  import defines_pkg::*;
#(
  parameter int unsigned REG_DATA_WD = 128,
  parameter int unsigned ADDR_WD     = 7,
  parameter int unsigned FLUSH_KEEP  = FLUSH_KEEP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_vld,
  input  logic [ADDR_WD-1:0]     iss_rt_addr,
  input  logic [2:0]             iss_idx,
  input  logic                   cmp_vld,
  input  logic [2:0]             cmp_stage,
  input  logic [REG_DATA_WD-1:0] cmp_data,
  input  logic                   flush,
  output logic [ADDR_WD-1:0]     rf_addr_s2,
  output logic [ADDR_WD-1:0]     rf_addr_s3,
  output logic [ADDR_WD-1:0]     rf_addr_s4,
  output logic [ADDR_WD-1:0]     rf_addr_s5,
  output logic [ADDR_WD-1:0]     rf_addr_s6,
  output logic [ADDR_WD-1:0]     rf_addr_s7,
  output logic [REG_DATA_WD-1:0] rf_data_s2,
  output logic [REG_DATA_WD-1:0] rf_data_s3,
  output logic [REG_DATA_WD-1:0] rf_data_s4,
  output logic [REG_DATA_WD-1:0] rf_data_s5,
  output logic [REG_DATA_WD-1:0] rf_data_s6,
  output logic [REG_DATA_WD-1:0] rf_data_s7,
  output logic [2:0]             rf_idx_s2,
  output logic [2:0]             rf_idx_s3,
  output logic [2:0]             rf_idx_s4,
  output logic [2:0]             rf_idx_s5,
  output logic [2:0]             rf_idx_s6,
  output logic [2:0]             rf_idx_s7,
  output logic [ADDR_WD-1:0]     rf_addr,
  output logic [REG_DATA_WD-1:0] rf_data,
  output logic                   rf_wr_en,
  output logic [2:0]             inflight_cnt,
  output logic                   err
);

  entry_t                 stg [2:WB_STAGE];
  entry_t                 d   [2:WB_STAGE];
  logic [WB_STAGE:2]      kill;
  logic [NUM_STAGES:2]    hit;
  logic                   cmp_flushed;
  logic                   wb_load;
  logic                   wb_bad;
  logic                   err_nxt;
  logic [2:0]             cnt_nxt;

  // Completion matching and flush kill masks. A stage index j kills the
  // entry arriving from j-1, so targets 2..FLUSH_KEEP drop flushed sources.
  always_comb begin
    hit  = '0;
    kill = '0;
    for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
      hit[k] = cmp_vld && (cmp_stage == k[2:0]) && stg[k].vld && !stg[k].rdy;
    end
    for (int unsigned j = 2; j <= WB_STAGE; j++) begin
      kill[j] = flush && (j <= FLUSH_KEEP);
    end
    cmp_flushed = flush && (cmp_stage >= 3'd2) && (32'(cmp_stage) < FLUSH_KEEP);
  end

  // Next entry for each stage: new issue into s2, shifted entry elsewhere
  // with the completion merged in while it moves.
  always_comb begin
    d[2]      = '0;
    d[2].vld  = iss_vld;
    d[2].rt   = ENTRY_ADDR_WD'(iss_rt_addr);
    d[2].idx  = iss_idx;
    for (int unsigned j = 3; j <= WB_STAGE; j++) begin
      d[j] = stg[j-1];
      if (hit[j-1]) begin
        d[j].rdy  = 1'b1;
        d[j].data = ENTRY_DATA_WD'(cmp_data);
      end
    end
  end

  for (genvar j = 2; j <= WB_STAGE; j++) begin : g_stage
    rp_stage u_stage (
      .clk     (clk),
      .rst     (rst),
      .capture (1'b1),
      .kill    (kill[j]),
      .d       (d[j]),
      .q       (stg[j])
    );
  end

  // Writeback load, protocol errors and occupancy of the post-edge state.
  always_comb begin
    wb_load = !kill[WB_STAGE] && d[WB_STAGE].vld && d[WB_STAGE].rdy;
    wb_bad  = !kill[WB_STAGE] && d[WB_STAGE].vld && !d[WB_STAGE].rdy;
    err_nxt = err || wb_bad || (cmp_vld && !(|hit) && !cmp_flushed);
    cnt_nxt = '0;
    for (int unsigned j = 2; j <= WB_STAGE; j++) begin
      if (!kill[j] && d[j].vld) begin
        cnt_nxt = cnt_nxt + 3'd1;
      end
    end
  end

  // Register-file port, sticky error flag and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_addr      <= '0;
      rf_data      <= '0;
      err          <= 1'b0;
      inflight_cnt <= '0;
    end else begin
      err          <= err_nxt;
      inflight_cnt <= cnt_nxt;
      if (wb_load) begin
        rf_addr <= d[WB_STAGE].rt[ADDR_WD-1:0];
        rf_data <= d[WB_STAGE].data[REG_DATA_WD-1:0];
      end
    end
  end

  assign rf_wr_en = stg[WB_STAGE].vld && stg[WB_STAGE].rdy;

  assign rf_addr_s2 = stg[2].vld ? stg[2].rt[ADDR_WD-1:0] : '0;
  assign rf_addr_s3 = stg[3].vld ? stg[3].rt[ADDR_WD-1:0] : '0;
  assign rf_addr_s4 = stg[4].vld ? stg[4].rt[ADDR_WD-1:0] : '0;
  assign rf_addr_s5 = stg[5].vld ? stg[5].rt[ADDR_WD-1:0] : '0;
  assign rf_addr_s6 = stg[6].vld ? stg[6].rt[ADDR_WD-1:0] : '0;
  assign rf_addr_s7 = stg[7].vld ? stg[7].rt[ADDR_WD-1:0] : '0;

  assign rf_data_s2 = stg[2].vld ? stg[2].data[REG_DATA_WD-1:0] : '0;
  assign rf_data_s3 = stg[3].vld ? stg[3].data[REG_DATA_WD-1:0] : '0;
  assign rf_data_s4 = stg[4].vld ? stg[4].data[REG_DATA_WD-1:0] : '0;
  assign rf_data_s5 = stg[5].vld ? stg[5].data[REG_DATA_WD-1:0] : '0;
  assign rf_data_s6 = stg[6].vld ? stg[6].data[REG_DATA_WD-1:0] : '0;
  assign rf_data_s7 = stg[7].vld ? stg[7].data[REG_DATA_WD-1:0] : '0;

  assign rf_idx_s2 = (stg[2].vld && stg[2].rdy) ? stg[2].idx : IDX_NONE;
  assign rf_idx_s3 = (stg[3].vld && stg[3].rdy) ? stg[3].idx : IDX_NONE;
  assign rf_idx_s4 = (stg[4].vld && stg[4].rdy) ? stg[4].idx : IDX_NONE;
  assign rf_idx_s5 = (stg[5].vld && stg[5].rdy) ? stg[5].idx : IDX_NONE;
  assign rf_idx_s6 = (stg[6].vld && stg[6].rdy) ? stg[6].idx : IDX_NONE;
  assign rf_idx_s7 = (stg[7].vld && stg[7].rdy) ? stg[7].idx : IDX_NONE;

endmodule

// File: tb/tb_result_pipe.sv
// Self-checking bench for result_pipe: directed scenarios plus random
// traffic against an age-based queue model of in-flight instructions.
module tb_result_pipe;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 7;
  localparam int FK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_vld;
  logic [AW-1:0] iss_rt_addr;
  logic [2:0]    iss_idx;
  logic          cmp_vld;
  logic [2:0]    cmp_stage;
  logic [DW-1:0] cmp_data;
  logic          flush;
  logic [AW-1:0] rf_addr_s2, rf_addr_s3, rf_addr_s4, rf_addr_s5, rf_addr_s6, rf_addr_s7;
  logic [DW-1:0] rf_data_s2, rf_data_s3, rf_data_s4, rf_data_s5, rf_data_s6, rf_data_s7;
  logic [2:0]    rf_idx_s2, rf_idx_s3, rf_idx_s4, rf_idx_s5, rf_idx_s6, rf_idx_s7;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          rf_wr_en;
  logic [2:0]    inflight_cnt;
  logic          err;

  always #5 clk = ~clk;

  result_pipe #(.REG_DATA_WD(DW), .ADDR_WD(AW), .FLUSH_KEEP(FK)) dut (
    .clk(clk), .rst(rst),
    .iss_vld(iss_vld), .iss_rt_addr(iss_rt_addr), .iss_idx(iss_idx),
    .cmp_vld(cmp_vld), .cmp_stage(cmp_stage), .cmp_data(cmp_data), .flush(flush),
    .rf_addr_s2(rf_addr_s2), .rf_addr_s3(rf_addr_s3), .rf_addr_s4(rf_addr_s4),
    .rf_addr_s5(rf_addr_s5), .rf_addr_s6(rf_addr_s6), .rf_addr_s7(rf_addr_s7),
    .rf_data_s2(rf_data_s2), .rf_data_s3(rf_data_s3), .rf_data_s4(rf_data_s4),
    .rf_data_s5(rf_data_s5), .rf_data_s6(rf_data_s6), .rf_data_s7(rf_data_s7),
    .rf_idx_s2(rf_idx_s2), .rf_idx_s3(rf_idx_s3), .rf_idx_s4(rf_idx_s4),
    .rf_idx_s5(rf_idx_s5), .rf_idx_s6(rf_idx_s6), .rf_idx_s7(rf_idx_s7),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_wr_en(rf_wr_en),
    .inflight_cnt(inflight_cnt), .err(err)
  );

  logic [AW-1:0] obs_addr [2:7];
  logic [DW-1:0] obs_data [2:7];
  logic [2:0]    obs_idx  [2:7];
  assign obs_addr[2] = rf_addr_s2; assign obs_addr[3] = rf_addr_s3; assign obs_addr[4] = rf_addr_s4;
  assign obs_addr[5] = rf_addr_s5; assign obs_addr[6] = rf_addr_s6; assign obs_addr[7] = rf_addr_s7;
  assign obs_data[2] = rf_data_s2; assign obs_data[3] = rf_data_s3; assign obs_data[4] = rf_data_s4;
  assign obs_data[5] = rf_data_s5; assign obs_data[6] = rf_data_s6; assign obs_data[7] = rf_data_s7;
  assign obs_idx[2]  = rf_idx_s2;  assign obs_idx[3]  = rf_idx_s3;  assign obs_idx[4]  = rf_idx_s4;
  assign obs_idx[5]  = rf_idx_s5;  assign obs_idx[6]  = rf_idx_s6;  assign obs_idx[7]  = rf_idx_s7;

  // Model: each in-flight instruction carries its current stage (8 = wb).
  typedef struct {
    int            st;
    logic [AW-1:0] rt;
    logic [2:0]    idx;
    logic          rdy;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic          m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q = {};
    m_err  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Apply the current inputs to the model for one clock edge.
  task automatic model_edge();
    ent_t nq[$];
    ent_t e;
    int   found;
    if (cmp_vld && !(flush && cmp_stage >= 3'd2 && int'(cmp_stage) < FK)) begin
      found = -1;
      foreach (q[i]) if (q[i].st == int'(cmp_stage)) found = i;
      if (found >= 0 && !q[found].rdy) begin
        q[found].rdy  = 1'b1;
        q[found].data = cmp_data;
      end else begin
        m_err = 1'b1;
      end
    end
    nq = {};
    foreach (q[i]) begin
      if (flush && q[i].st >= 2 && q[i].st < FK) continue;
      if (q[i].st == 8) continue;
      e = q[i];
      e.st = e.st + 1;
      nq.push_back(e);
    end
    if (iss_vld && !flush) begin
      e.st = 2; e.rt = iss_rt_addr; e.idx = iss_idx; e.rdy = 1'b0; e.data = '0;
      nq.push_back(e);
    end
    q = nq;
    foreach (q[i]) begin
      if (q[i].st == 8) begin
        if (q[i].rdy) begin
          m_addr = q[i].rt;
          m_data = q[i].data;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [2:0]    ei;
    logic          ew;
    for (int n = 2; n <= 7; n++) begin
      ea = '0; ed = '0; ei = '0;
      foreach (q[i]) begin
        if (q[i].st == n) begin
          ea = q[i].rt;
          ed = q[i].data;
          ei = q[i].rdy ? q[i].idx : 3'd0;
        end
      end
      chk($sformatf("%s addr_s%0d", tag, n), DW'(obs_addr[n]), DW'(ea));
      chk($sformatf("%s data_s%0d", tag, n), obs_data[n], ed);
      chk($sformatf("%s idx_s%0d", tag, n), DW'(obs_idx[n]), DW'(ei));
    end
    ew = 1'b0;
    foreach (q[i]) if (q[i].st == 8 && q[i].rdy) ew = 1'b1;
    chk({tag, " wr_en"}, DW'(rf_wr_en), DW'(ew));
    chk({tag, " rf_addr"}, DW'(rf_addr), DW'(m_addr));
    chk({tag, " rf_data"}, rf_data, m_data);
    chk({tag, " inflight"}, DW'(inflight_cnt), DW'(q.size()));
    chk({tag, " err"}, DW'(err), DW'(m_err));
  endtask

  task automatic drive(input logic iv, input logic [AW-1:0] rt, input logic [2:0] ix,
                       input logic cv, input logic [2:0] cs, input logic [DW-1:0] cd,
                       input logic fl);
    iss_vld = iv; iss_rt_addr = rt; iss_idx = ix;
    cmp_vld = cv; cmp_stage = cs; cmp_data = cd; flush = fl;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (n) step(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, " async"});
    @(posedge clk);
    #1;
    check_all({tag, " held"});
    rst = 1'b0;
  endtask

  logic [DW-1:0] a5;
  logic [DW-1:0] rnd;
  int            writes;
  int            peak;
  int            next_rt;
  logic          iv, cv, fl;
  logic [2:0]    cs;
  int            pick;
  int            r;

  initial begin
    a5 = {16{8'hA5}};
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    model_reset();
    check_all("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single issue, early completion, writeback seven cycles later.
    do_reset("r031");
    drive(1'b1, 7'd5, 3'd2, 1'b0, '0, '0, 1'b0);
    step("s031 c0");
    drive(1'b0, '0, '0, 1'b1, 3'd2, a5, 1'b0);
    step("s031 c1");
    chk("s031 idx_s3 c2", DW'(rf_idx_s3), DW'(3'd2));
    chk("s031 data_s3 c2", rf_data_s3, a5);
    idle(5, "s031 run");
    chk("s031 wr_en c7", DW'(rf_wr_en), DW'(1'b1));
    chk("s031 rf_addr c7", DW'(rf_addr), DW'(7'd5));
    chk("s031 rf_data c7", rf_data, a5);
    idle(1, "s031 c8");
    chk("s031 wr_en c8", DW'(rf_wr_en), DW'(1'b0));
    chk("s031 hold c8", DW'(rf_addr), DW'(7'd5));

    // Entry reaching wb without completion: no write, error raised.
    drive(1'b1, 7'd9, 3'd3, 1'b0, '0, '0, 1'b0);
    step("s035 iss");
    idle(6, "s035 run");
    chk("s035 wr_en", DW'(rf_wr_en), DW'(1'b0));
    chk("s035 rf_addr held", DW'(rf_addr), DW'(7'd5));
    chk("s035 rf_data held", rf_data, a5);
    chk("s035 err", DW'(err), DW'(1'b1));

    // Back-to-back issues completed at stage 7.
    do_reset("r032");
    writes = 0; peak = 0; next_rt = 1;
    for (int c = 0; c < 14; c++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive(c < 7, AW'(c + 1), 3'(c % 7 + 1), c >= 6 && c < 13, 3'd7, rnd, 1'b0);
      step("s032");
      if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
      if (rf_wr_en) begin
        chk("s032 order", DW'(rf_addr), DW'(next_rt));
        next_rt++;
        writes++;
      end
    end
    chk("s032 writes", DW'(writes), DW'(7));
    chk("s032 peak", DW'(peak), DW'(7));
    chk("s032 err", DW'(err), DW'(1'b0));

    // Flush with four issues: only the oldest survives.
    do_reset("r033");
    writes = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, AW'(c + 1), 3'd1, c == 3, 3'd4, a5, c == 3);
      step("s033 iss");
    end
    chk("s033 inflight", DW'(inflight_cnt), DW'(1));
    for (int c = 0; c < 8; c++) begin
      idle(1, "s033 run");
      if (rf_wr_en) begin
        writes++;
        chk("s033 addr", DW'(rf_addr), DW'(1));
      end
    end
    chk("s033 writes", DW'(writes), DW'(1));
    chk("s033 err", DW'(err), DW'(1'b0));

    // Flush beats a completion to the flushed stage.
    do_reset("r024");
    drive(1'b1, 7'd3, 3'd4, 1'b0, '0, '0, 1'b0);
    step("s024 iss");
    drive(1'b0, '0, '0, 1'b1, 3'd2, a5, 1'b1);
    step("s024 flush");
    chk("s024 err", DW'(err), DW'(1'b0));
    chk("s024 inflight", DW'(inflight_cnt), DW'(0));
    idle(7, "s024 run");
    chk("s024 err late", DW'(err), DW'(1'b0));

    // Bad completions: empty stage, out-of-range stage, already ready.
    do_reset("r034");
    drive(1'b0, '0, '0, 1'b1, 3'd4, a5, 1'b0);
    step("s034 empty");
    chk("s034 err", DW'(err), DW'(1'b1));
    chk("s034 wr_en", DW'(rf_wr_en), DW'(1'b0));
    idle(3, "s034 sticky");
    chk("s034 err sticky", DW'(err), DW'(1'b1));
    do_reset("r034b");
    chk("s034 err cleared", DW'(err), DW'(1'b0));
    drive(1'b0, '0, '0, 1'b1, 3'd1, a5, 1'b0);
    step("s034 range");
    chk("s034 err range", DW'(err), DW'(1'b1));
    do_reset("r034c");
    drive(1'b1, 7'd8, 3'd5, 1'b0, '0, '0, 1'b0);
    step("s034 iss");
    drive(1'b0, '0, '0, 1'b1, 3'd2, a5, 1'b0);
    step("s034 cmp1");
    chk("s034 err first", DW'(err), DW'(1'b0));
    drive(1'b0, '0, '0, 1'b1, 3'd3, ~a5, 1'b0);
    step("s034 cmp2");
    chk("s034 err twice", DW'(err), DW'(1'b1));
    chk("s034 data kept", rf_data_s4, a5);

    // Reset with five entries in flight.
    do_reset("r036");
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, AW'(c + 20), 3'd6, c > 0, 3'd2, a5, 1'b0);
      step("s036 fill");
    end
    chk("s036 inflight", DW'(inflight_cnt), DW'(5));
    do_reset("s036 rst");
    chk("s036 inflight0", DW'(inflight_cnt), DW'(0));
    idle(8, "s036 after");
    chk("s036 no write", DW'(rf_addr), DW'(0));

    // Random traffic with periodic mid-flight resets.
    do_reset("rnd");
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 59) do_reset("rnd rst");
      iv = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 6);
      cv = 1'b0;
      cs = 3'd0;
      r = $urandom_range(0, 99);
      if (r < 60 && q.size() > 0) begin
        pick = $urandom_range(0, q.size() - 1);
        if (q[pick].st <= 7) begin
          cv = 1'b1;
          cs = 3'(q[pick].st);
        end
      end else if (r < 66) begin
        cv = 1'b1;
        cs = 3'($urandom_range(0, 7));
      end
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive(iv, AW'($urandom), 3'($urandom_range(1, 7)), cv, cs, rnd, fl);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
